// File: rtl/vga_fetch.sv
// Frame-buffer read fetcher: turns vga_write pixel-pair strobes into raster-ordered
// word reads and owns the display/write double-buffer select.
module vga_fetch #(
  parameter int H_PIXELS    = 640,
  parameter int V_PIXELS    = 480,
  parameter int FRAME_WORDS = H_PIXELS * V_PIXELS / 2,
  parameter int BASE0       = 0,
  parameter int BASE1       = 153600,
  parameter int MEM_LATENCY = 1,
  parameter int LOG_TRUNC   = 18,
  parameter int LOG_MEM     = 2 * LOG_TRUNC
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_flag,
  input  logic               vga_flag,
  output logic [LOG_MEM-1:0] vga_pixel,
  output logic               done_vga,
  output logic [18:0]        mem_addr,
  output logic               mem_re,
  input  logic [LOG_MEM-1:0] mem_din,
  input  logic               swap_req,
  output logic               swap_ack,
  output logic               display_sel
);

  localparam logic [17:0] LAST_WORD = 18'(FRAME_WORDS - 1);
  localparam logic [18:0] BASE0_A   = 19'(BASE0);
  localparam logic [18:0] BASE1_A   = 19'(BASE1);

  logic [17:0]            word_cnt;
  logic                   swap_pending;
  logic [MEM_LATENCY-1:0] valid_pipe;
  logic [MEM_LATENCY-1:0] last_pipe;
  logic                   req;
  logic                   at_last;
  logic                   capture;

  // A frame restart in the same cycle as a strobe cancels the read.
  assign req     = vga_flag & ~frame_flag & ~reset;
  assign mem_re  = req;
  assign at_last = (word_cnt == LAST_WORD);
  // Returning data is dropped if the frame restarts as it lands.
  assign capture = valid_pipe[MEM_LATENCY-1] & ~frame_flag;

  assign mem_addr = reset ? BASE0_A
                          : ((display_sel ? BASE1_A : BASE0_A) + 19'(word_cnt));

  always_ff @(posedge clock) begin
    if (reset) begin
      word_cnt     <= '0;
      display_sel  <= 1'b0;
      swap_pending <= 1'b0;
      valid_pipe   <= '0;
      last_pipe    <= '0;
      vga_pixel    <= '0;
      done_vga     <= 1'b0;
      swap_ack     <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      done_vga <= 1'b0;
      if (capture) begin
        vga_pixel <= mem_din;
        done_vga  <= last_pipe[MEM_LATENCY-1];
      end
      if (frame_flag) begin
        word_cnt   <= '0;
        valid_pipe <= '0;
        last_pipe  <= '0;
        if (swap_pending | swap_req) begin
          display_sel  <= ~display_sel;
          swap_pending <= 1'b0;
          swap_ack     <= 1'b1;
        end
      end else begin
        swap_pending  <= swap_pending | swap_req;
        valid_pipe[0] <= req;
        last_pipe[0]  <= req & at_last;
        for (int i = 1; i < MEM_LATENCY; i++) begin
          valid_pipe[i] <= valid_pipe[i-1];
          last_pipe[i]  <= last_pipe[i-1];
        end
        if (req) word_cnt <= at_last ? '0 : word_cnt + 18'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_fetch.sv
// Randomized + directed bench for vga_fetch against a cycle-level reference model
// built from the frame/word rules, with a small frame to keep runs short.
module tb_vga_fetch;
  localparam int HP = 32, VP = 8;
  localparam int FW = HP * VP / 2;
  localparam int B1 = FW;
  localparam int LM = 36;

  logic          clock = 0;
  logic          reset, frame_flag, vga_flag, swap_req;
  logic [LM-1:0] vga_pixel, mem_din;
  logic          done_vga, mem_re, swap_ack, display_sel;
  logic [18:0]   mem_addr;

  int n_cmp = 0, n_bad = 0, done_seen = 0;

  // reference model state
  int          m_cnt;
  bit          m_sel, m_pend, m_ack, m_done;
  logic [LM-1:0] m_pix;
  bit          f_v, f_last;
  logic [LM-1:0] f_data;

  vga_fetch #(.H_PIXELS(HP), .V_PIXELS(VP), .BASE0(0), .BASE1(B1),
              .MEM_LATENCY(1), .LOG_TRUNC(18), .LOG_MEM(LM)) dut (
    .clock(clock), .reset(reset), .frame_flag(frame_flag), .vga_flag(vga_flag),
    .vga_pixel(vga_pixel), .done_vga(done_vga), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_din(mem_din), .swap_req(swap_req), .swap_ack(swap_ack), .display_sel(display_sel)
  );

  always #5 clock = ~clock;

  function automatic logic [LM-1:0] mem_word(input logic [18:0] a);
    return {a[17:0] ^ 18'h2A5A5, a[17:0]};
  endfunction

  // one-cycle-latency memory
  always @(posedge clock) if (mem_re) mem_din <= mem_word(mem_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit vf, input bit ff, input bit sr, input bit rst);
    bit          re;
    logic [18:0] a;
    @(negedge clock);
    vga_flag = vf; frame_flag = ff; swap_req = sr; reset = rst;
    #1;
    re = vf && !ff && !rst;
    a  = rst ? 19'd0 : 19'((m_sel ? B1 : 0) + m_cnt);
    chk("mem_re", 64'(mem_re), 64'(re));
    chk("mem_addr", 64'(mem_addr), 64'(a));
    @(posedge clock);
    if (rst) begin
      m_cnt = 0; m_sel = 0; m_pend = 0; m_ack = 0; m_done = 0; m_pix = '0; f_v = 0; f_last = 0;
    end else begin
      m_done = 0; m_ack = 0;
      if (f_v && !ff) begin m_pix = f_data; m_done = f_last; end
      if (ff) begin
        f_v = 0;
        m_cnt = 0;
        if (m_pend || sr) begin m_sel = !m_sel; m_pend = 0; m_ack = 1; end
      end else begin
        f_v = re; f_data = mem_word(a); f_last = re && (m_cnt == FW - 1);
        m_pend = m_pend || sr;
        if (re) m_cnt = (m_cnt + 1) % FW;
      end
    end
    #1;
    chk("vga_pixel", 64'(vga_pixel), 64'(m_pix));
    chk("done_vga", 64'(done_vga), 64'(m_done));
    chk("swap_ack", 64'(swap_ack), 64'(m_ack));
    chk("display_sel", 64'(display_sel), 64'(m_sel));
    if (done_vga === 1'b1) done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  int d0;

  initial begin
    vga_flag = 0; frame_flag = 0; swap_req = 0; reset = 1;
    m_cnt = 0; m_sel = 0; m_pend = 0; m_ack = 0; m_done = 0; m_pix = '0; f_v = 0; f_last = 0;
    f_data = '0;
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    idle(1);

    // three spaced requests
    for (int i = 0; i < 3; i++) begin step(1, 0, 0, 0); idle(2); end

    // full frame back-to-back: exactly one done pulse
    step(0, 1, 0, 0);
    d0 = done_seen;
    for (int i = 0; i < FW; i++) step(1, 0, 0, 0);
    idle(2);
    chk("done_count", 64'(done_seen - d0), 64'd1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);

    // swap mid-frame, then a frame with no swap request
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("sel_after_swap", 64'(display_sel), 64'd1);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("sel_held", 64'(display_sel), 64'd1);

    // collision at word 57, then in-flight read killed by frame restart
    for (int i = 0; i < 57; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    idle(1);

    // wrap without frame_flag: no swap, continues at word 0 of same buffer
    for (int i = 0; i < FW + 4; i++) step(1, 0, 0, 0);
    idle(2);

    // back-to-back burst of 4
    step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    idle(2);

    // reset mid-frame with pending swap and buffer 1 displayed
    for (int i = 0; i < 40; i++) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("sel_after_reset", 64'(display_sel), 64'd0);
    step(0, 1, 0, 0);
    chk("pending_dropped", 64'(swap_ack), 64'd0);
    step(1, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 60, $urandom_range(0, 199) < 3,
           $urandom_range(0, 99) < 3, $urandom_range(0, 999) < 4);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_fetch.md
# vga_fetch

Read-side frame-buffer fetcher that serves `vga_write` pixel-pair requests from the ZBT frame memory. It converts each `vga_flag` strobe into a raster-ordered word read, returns the word on `vga_pixel` in time for `vga_write`'s READING state, and pulses `done_vga` after the last word of a frame. It owns the double-buffer select, swapping displayed and write buffers only on frame boundaries. It sits between the memory interface's VGA read port and `vga_write`.

## Interface
- `H_PIXELS`, 640: visible pixels per line.
- `V_PIXELS`, 480: visible lines per frame.
- `FRAME_WORDS`, H_PIXELS*V_PIXELS/2 = 153600: words per frame, two pixels per word.
- `BASE0`, 0: word address of buffer 0.
- `BASE1`, 153600: word address of buffer 1.
- `MEM_LATENCY`, 1: cycles from `mem_re` to valid `mem_din`. Must be 1 for `vga_write` compatibility.
- `clock`  in  1  system clock; the only clock. Memory and `vga_write` fetch side share it.
- `reset`  in  1  synchronous, active-high.
- `frame_flag`  in  1  start-of-frame strobe, one cycle.
- `vga_flag`  in  1  pixel-pair request from `vga_write`, one-cycle strobe.
- `vga_pixel`  out  `LOG_MEM`  returned pixel pair; the upper `LOG_TRUNC` bits are the left pixel.
- `done_vga`  out  1  one-cycle pulse when the last word of the frame is presented.
- `mem_addr`  out  19  word read address.
- `mem_re`  out  1  read strobe to the memory interface.
- `mem_din`  in  `LOG_MEM`  read data.
- `swap_req`  in  1  writer requests a buffer swap at the next frame boundary.
- `swap_ack`  out  1  one-cycle pulse when the swap is applied.
- `display_sel`  out  1  buffer currently displayed. The writer uses `~display_sel`.

## Operation
- Registers:
  - `word_cnt`, 18 bits, range 0..FRAME_WORDS-1.
  - `display_sel`.
  - `swap_pending`.
  - `valid_pipe[MEM_LATENCY-1:0]`.
  - `last_pipe[MEM_LATENCY-1:0]`.
  - `vga_pixel`.
  - `done_vga`.
  - `swap_ack`.
- `req = vga_flag & ~frame_flag & ~reset`. This is combinational.
- `mem_re = req`.
- `mem_addr = (display_sel ? BASE1 : BASE0) + word_cnt`. This is combinational from registers and is valid every cycle.
- On `req`:
  - `word_cnt` increments.
  - At FRAME_WORDS-1 it wraps to 0.
  - `req` shifts into `valid_pipe`.
  - `(word_cnt == FRAME_WORDS-1)` shifts into `last_pipe`.
- When `valid_pipe` output is 1:
  - `vga_pixel <= mem_din`.
  - `done_vga <= last_pipe` output.
- Otherwise `vga_pixel` holds and `done_vga <= 0`.
- `swap_req` sets `swap_pending`. It is level or pulse; repeats while pending are absorbed.
- On `frame_flag`:
  - `word_cnt <= 0`.
  - `valid_pipe` and `last_pipe` are cleared, discarding in-flight reads.
  - If `swap_pending`, or `swap_req` in the same cycle: toggle `display_sel`, clear `swap_pending`, and pulse `swap_ack`.
- There is no state machine beyond these counters. Behaviour is fully pipelined; back-to-back requests are legal every cycle.

## Timing
- Reset values:
  - `word_cnt` = 0.
  - `display_sel` = 0.
  - `swap_pending` = 0.
  - `valid_pipe` and `last_pipe` = 0.
  - `vga_pixel` = 0.
  - `done_vga` = 0.
  - `swap_ack` = 0.
- Combinational outputs during reset: `mem_re` = 0, `mem_addr` = BASE0.
- Request latency:
  - `vga_flag` high in cycle t puts the address on `mem_addr` in cycle t.
  - `mem_din` is valid in cycle t+1.
  - `vga_pixel` is valid from cycle t+2 until the next capture. `vga_write` samples it at the end of t+2.
- `done_vga` is high for exactly cycle t+2 of the request that read word FRAME_WORDS-1.
- `swap_ack` and the new `display_sel` are visible in cycle f+1 after `frame_flag` in cycle f. The first request of the new frame uses the new base.
- Boundary conditions:
  - `vga_flag` and `frame_flag` in the same cycle: no read, no count. The frame restart wins.
  - Request at `word_cnt` = FRAME_WORDS-1 without `frame_flag`: served, then wraps to 0. A further request reads word 0 of the same buffer. No swap happens on wrap.
  - `frame_flag` during an in-flight read: the data is not loaded, and no `done_vga` is produced.
  - `reset` mid-frame: all registers return to reset values on the next edge. A `swap_req` arriving with `reset` is dropped.

## Test plan
- Reset, then 3 `vga_flag` pulses 3 cycles apart; memory model returns `mem_din = addr`.
  - Required: `mem_addr` = 0, 1, 2 in the request cycles.
  - Required: `vga_pixel` = 0, 1, 2, each appearing 2 cycles after its request.
- Frame run: 153600 requests, then `frame_flag`.
  - Required: `done_vga` pulses once, 2 cycles after the request at `mem_addr` 153599.
  - Required: the next request after `frame_flag` is at `mem_addr` 0.
- Swap: `swap_req` pulse mid-frame, then `frame_flag` at cycle f.
  - Required: `swap_ack` = 1 and `display_sel` = 1 at f+1.
  - Required: the next request is at `mem_addr` 153600.
  - Required: a second `frame_flag` with no `swap_req` leaves `display_sel` = 1.
- Collision: `vga_flag` and `frame_flag` in the same cycle, with `word_cnt` = 57 beforehand.
  - Required: `mem_re` = 0 and `word_cnt` becomes 0.
  - Required: a request at t, then `frame_flag` at t+1, leaves `vga_pixel` unchanged and `done_vga` = 0.
- Back-to-back: `vga_flag` high for 4 consecutive cycles.
  - Required: addresses 0..3 are issued consecutively, and `vga_pixel` steps through 4 values on consecutive cycles.
- Reset mid-frame at `word_cnt` = 1000 with `display_sel` = 1 and `swap_pending` = 1.
  - Required: all reset values restored, and the next request is at `mem_addr` 0.
